// File: rtl/mem_access_unit_pkg.sv
// Shared memory-op encodings, FSM state type and access-size helpers for the
// MEM-stage data-memory access unit.
package mem_access_unit_pkg;

    localparam logic [3:0] MEM_NONE = 4'd0;
    localparam logic [3:0] MEM_LB   = 4'd1;
    localparam logic [3:0] MEM_LBU  = 4'd2;
    localparam logic [3:0] MEM_LH   = 4'd3;
    localparam logic [3:0] MEM_LHU  = 4'd4;
    localparam logic [3:0] MEM_LW   = 4'd5;
    localparam logic [3:0] MEM_SB   = 4'd6;
    localparam logic [3:0] MEM_SH   = 4'd7;
    localparam logic [3:0] MEM_SW   = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mau_state_e;

    // Access size in bytes; 0 marks MEM_NONE or an unknown code.
    function automatic logic [2:0] op_size(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: op_size = 3'd1;
            MEM_LH, MEM_LHU, MEM_SH: op_size = 3'd2;
            MEM_LW, MEM_SW:          op_size = 3'd4;
            default:                 op_size = 3'd0;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        case (op)
            MEM_SB, MEM_SH, MEM_SW: op_is_store = 1'b1;
            default:                op_is_store = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_ext.sv
// Lane/halfword extraction and sign/zero extension of a loaded word.
// Purely combinational so a future cache path can reuse it.
module mem_load_ext
    import mem_access_unit_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [31:0] shifted_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte/halfword and extend it according to the op.
    always_comb begin
        shifted_s = word >> {lane, 3'b000};
        byte_s    = shifted_s[7:0];
        half_s    = lane[1] ? word[31:16] : word[15:0];
        case (op)
            MEM_LB:  result = {{24{byte_s[7]}}, byte_s};
            MEM_LBU: result = {24'd0, byte_s};
            MEM_LH:  result = {{16{half_s[15]}}, half_s};
            MEM_LHU: result = {16'd0, half_s};
            MEM_LW:  result = word;
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: turns EX/MEM load/store control into a registered
// request/ready bus transaction, stalls until done, and returns extended loads.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  ex_mem_mem_op,
    input  logic [31:0] ex_mem_alu_result,
    input  logic [31:0] ex_mem_rt_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_w_data,
    input  logic [31:0] dmem_r_data,
    input  logic        dmem_ready,
    output logic [31:0] dm_r_data,
    output logic        mem_stall,
    output logic        mem_exc
);

    mau_state_e  state_r, state_next_s;
    logic [2:0]  size_s;
    logic        valid_op_s, misaligned_s, start_s;
    logic [3:0]  be_s;
    logic [31:0] w_data_s;
    logic [3:0]  op_r;
    logic [1:0]  lane_r;
    logic [31:0] load_ext_s;

    // Decode the presented op: validity, alignment and store lane/enable shaping.
    always_comb begin
        size_s     = op_size(ex_mem_mem_op);
        valid_op_s = (size_s != 3'd0);
        case (size_s)
            3'd2:    misaligned_s = ex_mem_alu_result[0];
            3'd4:    misaligned_s = (ex_mem_alu_result[1:0] != 2'b00);
            default: misaligned_s = 1'b0;
        endcase
        start_s = valid_op_s & ~misaligned_s;
        case (ex_mem_mem_op)
            MEM_SB: begin
                be_s     = 4'b0001 << ex_mem_alu_result[1:0];
                w_data_s = {4{ex_mem_rt_data[7:0]}};
            end
            MEM_SH: begin
                be_s     = 4'b0011 << {ex_mem_alu_result[1], 1'b0};
                w_data_s = {2{ex_mem_rt_data[15:0]}};
            end
            default: begin
                be_s     = 4'b1111;
                w_data_s = ex_mem_rt_data;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic plus the combinational stall/exception outputs.
    always_comb begin
        state_next_s = state_r;
        mem_stall    = 1'b0;
        mem_exc      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_next_s = ST_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
                mem_stall = start_s;
                mem_exc   = valid_op_s & misaligned_s;
            end
            ST_BUSY: begin
                if (dmem_ready) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_BUSY;
                end
                mem_stall = 1'b1;
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        if (reset) begin
            mem_stall = 1'b0;
            mem_exc   = 1'b0;
        end else begin
            mem_stall = mem_stall;
            mem_exc   = mem_exc;
        end
    end

    mem_load_ext u_load_ext (
        .op     (op_r),
        .lane   (lane_r),
        .word   (dmem_r_data),
        .result (load_ext_s)
    );

    // Bus outputs are captured once in IDLE and held until the next transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= 32'd0;
            dmem_be     <= 4'd0;
            dmem_w_data <= 32'd0;
            dm_r_data   <= 32'd0;
            op_r        <= MEM_NONE;
            lane_r      <= 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        dmem_req    <= 1'b1;
                        dmem_we     <= op_is_store(ex_mem_mem_op);
                        dmem_addr   <= {ex_mem_alu_result[31:2], 2'b00};
                        dmem_be     <= be_s;
                        dmem_w_data <= w_data_s;
                        op_r        <= ex_mem_mem_op;
                        lane_r      <= ex_mem_alu_result[1:0];
                    end
                end
                ST_BUSY: begin
                    if (dmem_ready) begin
                        dmem_req <= 1'b0;
                        if (!op_is_store(op_r)) begin
                            dm_r_data <= load_ext_s;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a transaction-level model.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  ex_mem_mem_op;
    logic [31:0] ex_mem_alu_result, ex_mem_rt_data;
    logic        dmem_req, dmem_we, dmem_ready, mem_stall, mem_exc;
    logic [31:0] dmem_addr, dmem_w_data, dmem_r_data, dm_r_data;
    logic [3:0]  dmem_be;

    mem_access_unit dut (
        .clk(clk), .reset(reset),
        .ex_mem_mem_op(ex_mem_mem_op), .ex_mem_alu_result(ex_mem_alu_result),
        .ex_mem_rt_data(ex_mem_rt_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_w_data(dmem_w_data),
        .dmem_r_data(dmem_r_data), .dmem_ready(dmem_ready),
        .dm_r_data(dm_r_data), .mem_stall(mem_stall), .mem_exc(mem_exc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_fail = 0, stall_cnt = 0;
    bit chk_en = 1'b0;
    // model of registered state and per-cycle expectations
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wd, m_dm;
    logic [3:0]  m_be;
    logic        e_req, e_we, e_stall, e_exc;
    logic [31:0] e_addr, e_wd, e_dm;
    logic [3:0]  e_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dmem_req",    32'(dmem_req),    32'(e_req));
            chk("dmem_we",     32'(dmem_we),     32'(e_we));
            chk("dmem_addr",   dmem_addr,        e_addr);
            chk("dmem_be",     32'(dmem_be),     32'(e_be));
            chk("dmem_w_data", dmem_w_data,      e_wd);
            chk("dm_r_data",   dm_r_data,        e_dm);
            chk("mem_stall",   32'(mem_stall),   32'(e_stall));
            chk("mem_exc",     32'(mem_exc),     32'(e_exc));
        end
    end

    function automatic int size_of(input logic [3:0] o);
        if (o == MEM_LB || o == MEM_LBU || o == MEM_SB) return 1;
        if (o == MEM_LH || o == MEM_LHU || o == MEM_SH) return 2;
        if (o == MEM_LW || o == MEM_SW) return 4;
        return 0;
    endfunction

    function automatic bit is_st(input logic [3:0] o);
        return (o == MEM_SB || o == MEM_SH || o == MEM_SW);
    endfunction

    function automatic logic [3:0] f_be(input logic [3:0] o, input logic [31:0] a);
        int sz;
        sz = size_of(o);
        if (!is_st(o) || sz == 4) return 4'hF;
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] f_wd(input logic [3:0] o, input logic [31:0] r);
        if (o == MEM_SB) return (r & 32'hFF) * 32'h0101_0101;
        if (o == MEM_SH) return (r & 32'hFFFF) * 32'h0001_0001;
        return r;
    endfunction

    function automatic logic [31:0] f_ext(input logic [3:0] o, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v;
        v = w >> (8 * (a % 4));
        if (o == MEM_LBU) return v & 32'hFF;
        if (o == MEM_LHU) return v & 32'hFFFF;
        if (o == MEM_LB)  return ((v & 32'hFF) >= 32'd128) ? (v & 32'hFF) - 32'd256 : (v & 32'hFF);
        if (o == MEM_LH)  return ((v & 32'hFFFF) >= 32'd32768) ? (v & 32'hFFFF) - 32'd65536 : (v & 32'hFFFF);
        return w;
    endfunction

    task automatic load_exp();
        e_req = m_req; e_we = m_we; e_addr = m_addr; e_be = m_be; e_wd = m_wd; e_dm = m_dm;
    endtask

    task automatic clear_model();
        m_req = 1'b0; m_we = 1'b0; m_addr = 32'd0; m_be = 4'd0; m_wd = 32'd0; m_dm = 32'd0;
    endtask

    task automatic step();
        #1;
        if (mem_stall) stall_cnt++;
        @(posedge clk);
        #1;
    endtask

    // One EX/MEM op from first presentation through DONE (or rejection/reset).
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] r,
                          input logic [31:0] w, input int waits, input int rst_cyc);
        int sz;
        bit mis;
        sz = size_of(o);
        mis = (sz > 1) && ((a % sz) != 0);
        stall_cnt = 0;
        ex_mem_mem_op = o; ex_mem_alu_result = a; ex_mem_rt_data = r;
        dmem_ready = 1'($urandom_range(0, 1)); dmem_r_data = $urandom;
        load_exp(); e_exc = mis; e_stall = (sz > 0) && !mis;
        step();
        if (sz == 0 || mis) return;
        m_req = 1'b1; m_we = is_st(o); m_addr = a & ~32'd3; m_be = f_be(o, a); m_wd = f_wd(o, r);
        for (int i = 1; i <= waits + 1; i++) begin
            dmem_ready = (i == waits + 1);
            dmem_r_data = dmem_ready ? w : $urandom;
            load_exp(); e_exc = 1'b0; e_stall = 1'b1;
            if (i == rst_cyc) begin
                reset = 1'b1; e_stall = 1'b0;
                step();
                reset = 1'b0;
                clear_model();
                return;
            end
            step();
        end
        m_req = 1'b0;
        if (!is_st(o)) m_dm = f_ext(o, a, w);
        dmem_ready = 1'($urandom_range(0, 1)); dmem_r_data = $urandom;
        load_exp(); e_exc = 1'b0; e_stall = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; ex_mem_mem_op = MEM_NONE; ex_mem_alu_result = 32'd0; ex_mem_rt_data = 32'd0;
        dmem_ready = 1'b0; dmem_r_data = 32'd0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        // misaligned op under reset: exception and stall must stay low
        ex_mem_mem_op = MEM_SW; ex_mem_alu_result = 32'h41;
        load_exp(); e_exc = 1'b0; e_stall = 1'b0; chk_en = 1'b1;
        step();
        reset = 1'b0;
        run_op(MEM_NONE, 32'h0, 32'h0, 32'h0, 0, -1);
        chk("reset_dm", dm_r_data, 32'h0);

        run_op(MEM_LW, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, -1);
        chk("lw_stall_cycles", 32'(stall_cnt), 32'd2);
        chk("lw_dm", dm_r_data, 32'hDEAD_BEEF);
        chk("lw_addr", dmem_addr, 32'h10);
        chk("lw_be", 32'(dmem_be), 32'hF);

        run_op(MEM_LB, 32'h13, 32'h0, 32'h8012_3456, 1, -1);
        chk("lb_dm", dm_r_data, 32'hFFFF_FF80);
        run_op(MEM_LBU, 32'h13, 32'h0, 32'h8012_3456, 0, -1);
        chk("lbu_dm", dm_r_data, 32'h0000_0080);

        run_op(MEM_SH, 32'h22, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, -1);
        chk("sh_addr", dmem_addr, 32'h20);
        chk("sh_be", 32'(dmem_be), 32'hC);
        chk("sh_wd", dmem_w_data, 32'hABCD_ABCD);
        chk("sh_we", 32'(dmem_we), 32'h1);
        chk("sh_dm_kept", dm_r_data, 32'h0000_0080);

        run_op(MEM_SW, 32'h41, 32'h5555_5555, 32'h0, 0, -1);
        chk("sw_mis_stall", 32'(stall_cnt), 32'd0);
        chk("sw_mis_req", 32'(dmem_req), 32'd0);

        run_op(MEM_LH, 32'h8, 32'h0, 32'h1234_8001, 3, -1);
        chk("lh_stall_cycles", 32'(stall_cnt), 32'd5);
        chk("lh_dm", dm_r_data, 32'hFFFF_8001);

        run_op(MEM_LW, 32'h100, 32'h0, 32'hCAFE_F00D, 3, 2);
        run_op(MEM_NONE, 32'h0, 32'h0, 32'h0, 0, -1);
        chk("rst_busy_dm", dm_r_data, 32'h0);
        chk("rst_busy_req", 32'(dmem_req), 32'h0);

        for (int k = 0; k < 400; k++) begin
            logic [3:0]  ro;
            logic [31:0] ra;
            ro = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
            run_op(ro, ra, $urandom, $urandom, $urandom_range(0, 3), -1);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
